// File: rtl/alu_issue_control_pkg.sv
// Shared MIPS definitions for the ALU issue controller: opcodes, functs,
// ALUControl codes, FSM state encoding and the decoded-field bundle.
package alu_issue_control_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALUC_W  = 6;
    localparam int unsigned STATE_W = 3;

    // Primary opcodes
    localparam logic [OPC_W-1:0] OP_RTYPE    = 6'b000000;
    localparam logic [OPC_W-1:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [OPC_W-1:0] OP_ADDI     = 6'b001000;
    localparam logic [OPC_W-1:0] OP_ANDI     = 6'b001100;
    localparam logic [OPC_W-1:0] OP_ORI      = 6'b001101;
    localparam logic [OPC_W-1:0] OP_XORI     = 6'b001110;
    localparam logic [OPC_W-1:0] OP_SLTI     = 6'b001010;
    localparam logic [OPC_W-1:0] OP_BEQ      = 6'b000100;
    localparam logic [OPC_W-1:0] OP_BNE      = 6'b000101;
    localparam logic [OPC_W-1:0] OP_BLEZ     = 6'b000110;
    localparam logic [OPC_W-1:0] OP_BGTZ     = 6'b000111;

    // Function fields (R-type unless noted)
    localparam logic [FUNCT_W-1:0] F_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] F_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] F_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] F_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] F_XOR = 6'b100110;
    localparam logic [FUNCT_W-1:0] F_SLT = 6'b101010;
    localparam logic [FUNCT_W-1:0] F_SLL = 6'b000000;
    localparam logic [FUNCT_W-1:0] F_SRL = 6'b000010;
    localparam logic [FUNCT_W-1:0] F_MUL = 6'b000010;  // under OP_SPECIAL2

    // ALUControl codes understood by ALU32Bit
    localparam logic [ALUC_W-1:0] ALU_ADD  = 6'b100000;
    localparam logic [ALUC_W-1:0] ALU_SUB  = 6'b100010;
    localparam logic [ALUC_W-1:0] ALU_MUL  = 6'b011000;
    localparam logic [ALUC_W-1:0] ALU_AND  = 6'b100100;
    localparam logic [ALUC_W-1:0] ALU_OR   = 6'b100101;
    localparam logic [ALUC_W-1:0] ALU_XOR  = 6'b100110;
    localparam logic [ALUC_W-1:0] ALU_SLL  = 6'b000000;
    localparam logic [ALUC_W-1:0] ALU_SRL  = 6'b000010;
    localparam logic [ALUC_W-1:0] ALU_SLT  = 6'b101010;
    localparam logic [ALUC_W-1:0] ALU_BEQ  = 6'b000100;
    localparam logic [ALUC_W-1:0] ALU_BNE  = 6'b000101;
    localparam logic [ALUC_W-1:0] ALU_BLEZ = 6'b000110;
    localparam logic [ALUC_W-1:0] ALU_BGTZ = 6'b000111;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE      = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_BRANCH    = 3'd4,
        S_ERROR     = 3'd5
    } state_t;

    typedef struct packed {
        logic [ALUC_W-1:0] alu_control;
        logic              alu_src_b;
        logic              shamt_sel;
        logic              reg_dst;
        logic              is_branch;
        logic              illegal;
    } dec_t;

endpackage

// File: rtl/alu_issue_control_if.sv
// Instruction handshake plus ALU32Bit control bundle.
interface alu_issue_control_if;
    import alu_issue_control_pkg::*;

    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instruction;
    logic               zero;
    logic [ALUC_W-1:0]  alu_control;
    logic               alu_src_b;
    logic               shamt_sel;
    logic               reg_dst;
    logic               reg_write;
    logic               branch_taken;
    logic               illegal_instr;
    logic               done;

    // Issue controller side
    modport master (
        input  instr_valid, instruction, zero,
        output instr_ready, alu_control, alu_src_b, shamt_sel, reg_dst,
               reg_write, branch_taken, illegal_instr, done
    );

    // Fetch / datapath side
    modport slave (
        output instr_valid, instruction, zero,
        input  instr_ready, alu_control, alu_src_b, shamt_sel, reg_dst,
               reg_write, branch_taken, illegal_instr, done
    );
endinterface

// File: rtl/alu_issue_control_op_decoder.sv
// Combinational MIPS opcode/funct decoder producing ALU control and selects.
module alu_issue_control_op_decoder
    import alu_issue_control_pkg::*;
(
    input  logic [OPC_W-1:0]   opcode,
    input  logic [FUNCT_W-1:0] funct,
    output dec_t               dec
);

    // Map opcode/funct to ALU code and operand selects; anything unlisted is illegal
    always_comb begin
        dec             = '0;
        dec.alu_control = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                dec.reg_dst = 1'b1;
                case (funct)
                    F_ADD: dec.alu_control = ALU_ADD;
                    F_SUB: dec.alu_control = ALU_SUB;
                    F_AND: dec.alu_control = ALU_AND;
                    F_OR:  dec.alu_control = ALU_OR;
                    F_XOR: dec.alu_control = ALU_XOR;
                    F_SLT: dec.alu_control = ALU_SLT;
                    F_SLL: begin
                        dec.alu_control = ALU_SLL;
                        dec.shamt_sel   = 1'b1;
                    end
                    F_SRL: begin
                        dec.alu_control = ALU_SRL;
                        dec.shamt_sel   = 1'b1;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_SPECIAL2: begin
                dec.reg_dst = 1'b1;
                if (funct == F_MUL) dec.alu_control = ALU_MUL;
                else                dec.illegal     = 1'b1;
            end
            OP_ADDI: begin dec.alu_src_b = 1'b1; dec.alu_control = ALU_ADD; end
            OP_ANDI: begin dec.alu_src_b = 1'b1; dec.alu_control = ALU_AND; end
            OP_ORI:  begin dec.alu_src_b = 1'b1; dec.alu_control = ALU_OR;  end
            OP_XORI: begin dec.alu_src_b = 1'b1; dec.alu_control = ALU_XOR; end
            OP_SLTI: begin dec.alu_src_b = 1'b1; dec.alu_control = ALU_SLT; end
            OP_BEQ:  begin dec.is_branch = 1'b1; dec.alu_control = ALU_BEQ;  end
            OP_BNE:  begin dec.is_branch = 1'b1; dec.alu_control = ALU_BNE;  end
            OP_BLEZ: begin dec.is_branch = 1'b1; dec.alu_control = ALU_BLEZ; end
            OP_BGTZ: begin dec.is_branch = 1'b1; dec.alu_control = ALU_BGTZ; end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_control.sv
// Multi-cycle issue controller: accepts one instruction per handshake,
// decodes it, drives the ALU for one EXECUTE cycle and retires it.
module alu_issue_control
    import alu_issue_control_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    alu_issue_control_if.master bus
);

    state_t              state;
    logic [OPC_W-1:0]    opcode_q;
    logic [FUNCT_W-1:0]  funct_q;
    logic                is_branch_q;
    logic [ALUC_W-1:0]   alu_control_q;
    logic                alu_src_b_q;
    logic                shamt_sel_q;
    logic                reg_dst_q;
    logic                reg_write_q;
    logic                branch_taken_q;
    logic                illegal_q;
    logic                done_q;
    dec_t                dec;

    alu_issue_control_op_decoder u_decoder (
        .opcode (opcode_q),
        .funct  (funct_q),
        .dec    (dec)
    );

    // Ready is a pure state decode, forced low while reset is held
    assign bus.instr_ready   = (state == S_IDLE) && !rst;
    assign bus.alu_control   = alu_control_q;
    assign bus.alu_src_b     = alu_src_b_q;
    assign bus.shamt_sel     = shamt_sel_q;
    assign bus.reg_dst       = reg_dst_q;
    assign bus.reg_write     = reg_write_q;
    assign bus.branch_taken  = branch_taken_q;
    assign bus.illegal_instr = illegal_q;
    assign bus.done          = done_q;

    // Issue FSM with registered ALU controls and one-cycle retirement pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            opcode_q       <= '0;
            funct_q        <= '0;
            is_branch_q    <= 1'b0;
            alu_control_q  <= ALU_ADD;
            alu_src_b_q    <= 1'b0;
            shamt_sel_q    <= 1'b0;
            reg_dst_q      <= 1'b0;
            reg_write_q    <= 1'b0;
            branch_taken_q <= 1'b0;
            illegal_q      <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            reg_write_q    <= 1'b0;
            branch_taken_q <= 1'b0;
            illegal_q      <= 1'b0;
            done_q         <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        opcode_q <= bus.instruction[31:26];
                        funct_q  <= bus.instruction[5:0];
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (dec.illegal) begin
                        state <= S_ERROR;
                    end else begin
                        alu_control_q <= dec.alu_control;
                        alu_src_b_q   <= dec.alu_src_b;
                        shamt_sel_q   <= dec.shamt_sel;
                        reg_dst_q     <= dec.reg_dst;
                        is_branch_q   <= dec.is_branch;
                        state         <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    done_q <= 1'b1;
                    if (is_branch_q) begin
                        branch_taken_q <= bus.zero;
                        state          <= S_BRANCH;
                    end else begin
                        reg_write_q <= 1'b1;
                        state       <= S_WRITEBACK;
                    end
                end
                S_WRITEBACK, S_BRANCH: begin
                    state <= S_IDLE;
                end
                S_ERROR: begin
                    // First ERROR cycle stands in for EXECUTE so an illegal
                    // instruction retires with the same latency as a legal one
                    if (!illegal_q) begin
                        illegal_q <= 1'b1;
                        done_q    <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_control.sv
// Self-checking bench for alu_issue_control with a table-driven reference model.
module tb_alu_issue_control;
    import alu_issue_control_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    alu_issue_control_if bus();

    alu_issue_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference decode table: opcode, funct, funct-matters, code, srcb, shamt, regdst, branch
    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       use_fn;
        logic [5:0] code;
        logic       srcb;
        logic       shamt;
        logic       regdst;
        logic       br;
    } entry_t;

    entry_t tbl[18] = '{
        '{6'b000000, 6'b100000, 1'b1, 6'b100000, 1'b0, 1'b0, 1'b1, 1'b0},
        '{6'b000000, 6'b100010, 1'b1, 6'b100010, 1'b0, 1'b0, 1'b1, 1'b0},
        '{6'b000000, 6'b100100, 1'b1, 6'b100100, 1'b0, 1'b0, 1'b1, 1'b0},
        '{6'b000000, 6'b100101, 1'b1, 6'b100101, 1'b0, 1'b0, 1'b1, 1'b0},
        '{6'b000000, 6'b100110, 1'b1, 6'b100110, 1'b0, 1'b0, 1'b1, 1'b0},
        '{6'b000000, 6'b101010, 1'b1, 6'b101010, 1'b0, 1'b0, 1'b1, 1'b0},
        '{6'b000000, 6'b000000, 1'b1, 6'b000000, 1'b0, 1'b1, 1'b1, 1'b0},
        '{6'b000000, 6'b000010, 1'b1, 6'b000010, 1'b0, 1'b1, 1'b1, 1'b0},
        '{6'b011100, 6'b000010, 1'b1, 6'b011000, 1'b0, 1'b0, 1'b1, 1'b0},
        '{6'b001000, 6'b000000, 1'b0, 6'b100000, 1'b1, 1'b0, 1'b0, 1'b0},
        '{6'b001100, 6'b000000, 1'b0, 6'b100100, 1'b1, 1'b0, 1'b0, 1'b0},
        '{6'b001101, 6'b000000, 1'b0, 6'b100101, 1'b1, 1'b0, 1'b0, 1'b0},
        '{6'b001110, 6'b000000, 1'b0, 6'b100110, 1'b1, 1'b0, 1'b0, 1'b0},
        '{6'b001010, 6'b000000, 1'b0, 6'b101010, 1'b1, 1'b0, 1'b0, 1'b0},
        '{6'b000100, 6'b000000, 1'b0, 6'b000100, 1'b0, 1'b0, 1'b0, 1'b1},
        '{6'b000101, 6'b000000, 1'b0, 6'b000101, 1'b0, 1'b0, 1'b0, 1'b1},
        '{6'b000110, 6'b000000, 1'b0, 6'b000110, 1'b0, 1'b0, 1'b0, 1'b1},
        '{6'b000111, 6'b000000, 1'b0, 6'b000111, 1'b0, 1'b0, 1'b0, 1'b1}
    };

    localparam logic [8:0] RESET_SEL = {6'b100000, 3'b000};

    // Observation word: {ready, regwrite, branchtaken, illegal, done, alucontrol, srcb, shamt, regdst}
    logic [13:0] obs[5];
    logic [13:0] exp_w[5];
    logic [8:0]  held = RESET_SEL;

    logic [31:0] dir_ins[13] = '{
        32'h00221820, 32'h00221822, 32'h3022000F, 32'h00021080, 32'h00021082,
        32'h10220004, 32'h14220004, 32'h18200002, 32'h1C200003, 32'h70221002,
        32'hFC000000, 32'h28220009, 32'h70221000
    };
    logic dir_z[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    function automatic logic [13:0] sample();
        return {bus.instr_ready, bus.reg_write, bus.branch_taken, bus.illegal_instr,
                bus.done, bus.alu_control, bus.alu_src_b, bus.shamt_sel, bus.reg_dst};
    endfunction

    // Expected per-cycle words for one instruction, issued from IDLE with given Zero in EXECUTE
    task automatic predict(input logic [31:0] ins, input logic z);
        logic       legal = 1'b0;
        logic       br = 1'b0;
        logic [8:0] nsel;
        logic [5:0] op = ins[31:26];
        logic [5:0] fn = ins[5:0];
        nsel = held;
        foreach (tbl[i]) begin
            if (tbl[i].op == op && (!tbl[i].use_fn || tbl[i].fn == fn)) begin
                legal = 1'b1;
                br    = tbl[i].br;
                nsel  = {tbl[i].code, tbl[i].srcb, tbl[i].shamt, tbl[i].regdst};
            end
        end
        exp_w[0] = {1'b1, 4'b0000, held};
        exp_w[1] = {1'b0, 4'b0000, held};
        exp_w[2] = {1'b0, 4'b0000, nsel};
        exp_w[3] = {1'b0, legal && !br, legal && br && z, !legal, 1'b1, nsel};
        exp_w[4] = {1'b1, 4'b0000, nsel};
        held = nsel;
    endtask

    // Issue one instruction and record outputs for the accept cycle and four following
    task automatic run_one(input logic [31:0] ins, input logic z);
        @(negedge clk);
        obs[0] = sample();
        bus.instr_valid = 1'b1;
        bus.instruction = ins;
        bus.zero = 1'($urandom);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            obs[c] = sample();
            bus.instr_valid = 1'b0;
            bus.instruction = $urandom;
            bus.zero = (c == 2) ? z : 1'($urandom);
        end
    endtask

    task automatic test_reset();
        bus.instr_valid = 1'b0;
        bus.instruction = '0;
        bus.zero = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (sample() !== {1'b0, 4'b0000, RESET_SEL}) begin
            errors++;
            $display("FAIL reset_values: got %b expected %b", sample(), {1'b0, 4'b0000, RESET_SEL});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", bus.instr_ready);
        end
        held = RESET_SEL;
    endtask

    task automatic test_directed();
        for (int k = 0; k < 13; k++) begin
            predict(dir_ins[k], dir_z[k]);
            run_one(dir_ins[k], dir_z[k]);
            for (int c = 0; c < 5; c++) begin
                checks++;
                if (obs[c] !== exp_w[c]) begin
                    errors++;
                    $display("FAIL directed %h cycle %0d: got %b expected %b", dir_ins[k], c, obs[c], exp_w[c]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            logic [31:0] ins = $urandom;
            logic        z = 1'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                int e = $urandom_range(0, 17);
                ins[31:26] = tbl[e].op;
                if (tbl[e].use_fn) ins[5:0] = tbl[e].fn;
            end
            predict(ins, z);
            run_one(ins, z);
            for (int c = 0; c < 5; c++) begin
                checks++;
                if (obs[c] !== exp_w[c]) begin
                    errors++;
                    $display("FAIL random %h cycle %0d: got %b expected %b", ins, c, obs[c], exp_w[c]);
                end
            end
        end
    endtask

    // Valid held high: accepts every 4 cycles, ready low in between, retire 3 cycles after accept
    task automatic test_back_to_back();
        logic [2:0] got, want;
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instruction = 32'h20220005;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            got  = {bus.instr_ready, bus.done, bus.reg_write};
            want = {(i % 4) == 0, (i % 4) == 3, (i % 4) == 3};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got %b expected %b", i, got, want);
            end
            if (i == 11) bus.instr_valid = 1'b0;
        end
        held = {6'b100000, 3'b100};
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instruction = 32'h20230007;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (sample() !== {1'b0, 4'b0000, 6'b100000, 3'b100}) begin
            errors++;
            $display("FAIL reset_mid_execute: got %b expected %b", sample(), {1'b0, 4'b0000, 6'b100000, 3'b100});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (sample() !== {1'b0, 4'b0000, RESET_SEL}) begin
            errors++;
            $display("FAIL reset_mid_async: got %b expected %b", sample(), {1'b0, 4'b0000, RESET_SEL});
        end
        @(negedge clk);
        checks++;
        if (sample() !== {1'b0, 4'b0000, RESET_SEL}) begin
            errors++;
            $display("FAIL reset_mid_no_retire: got %b expected %b", sample(), {1'b0, 4'b0000, RESET_SEL});
        end
        rst = 1'b0;
        held = RESET_SEL;
        predict(32'h00432022, 1'b0);
        run_one(32'h00432022, 1'b0);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (obs[c] !== exp_w[c]) begin
                errors++;
                $display("FAIL reset_mid_next cycle %0d: got %b expected %b", c, obs[c], exp_w[c]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
